// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master SPRAM arbiter.
package ram_arb_pkg;

    localparam int NUM_MASTERS = 2;
    localparam int MASK_W      = 4;
    localparam int DATA_W      = 32;

    // Bus owner: nobody, master 0 (fetch) or master 1 (data).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

    // Map a winning master index onto its ownership state.
    function automatic owner_t owner_of(input logic master);
        return master ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Winner selection for the SPRAM arbiter.
// Define RAM_ARB_ROUND_ROBIN_EN to alternate on ties; otherwise m0 always wins a tie.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic m0_sel,
    input  logic m1_sel,
    input  logic last_grant,
    output logic any_req,
    output logic winner
);

    logic tie_winner;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // The master that did not finish the previous transaction gets the tie.
    assign tie_winner = ~last_grant;
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign tie_winner        = 1'b0;
`endif

    // Single requester wins outright; a tie defers to the policy.
    always_comb begin
        any_req = m0_sel | m1_sel;
        if (m0_sel && m1_sel) begin
            winner = tie_winner;
        end else begin
            winner = m1_sel;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master, one-slave arbiter sharing a single SPRAM between fetch (m0) and data (m1).
// Grant is registered per transaction; sel drops for a cycle between transactions so the
// RAM's toggling ready restarts from 0. Tie policy set by RAM_ARB_ROUND_ROBIN_EN.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_WIDTH-1:0] m0_address_in,
    input  logic                  m0_sel_in,
    input  logic [MASK_W-1:0]     m0_write_mask_in,
    input  logic [DATA_W-1:0]     m0_write_value_in,
    output logic [DATA_W-1:0]     m0_read_value_out,
    output logic                  m0_ready_out,

    input  logic [ADDR_WIDTH-1:0] m1_address_in,
    input  logic                  m1_sel_in,
    input  logic [MASK_W-1:0]     m1_write_mask_in,
    input  logic [DATA_W-1:0]     m1_write_value_in,
    output logic [DATA_W-1:0]     m1_read_value_out,
    output logic                  m1_ready_out,

    output logic [ADDR_WIDTH-1:0] s_address_out,
    output logic                  s_sel_out,
    output logic [MASK_W-1:0]     s_write_mask_out,
    output logic [DATA_W-1:0]     s_write_value_out,
    input  logic [DATA_W-1:0]     s_read_value_in,
    input  logic                  s_ready_in
);

    owner_t state;
    logic   last_grant;
    logic   any_req;
    logic   winner;

    ram_arb_pick u_pick (
        .m0_sel     (m0_sel_in),
        .m1_sel     (m1_sel_in),
        .last_grant (last_grant),
        .any_req    (any_req),
        .winner     (winner)
    );

    // Ownership FSM: grab the bus from IDLE, release on ready or when the owner abandons.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= owner_of(winner);
                    end
                end
                OWN0: begin
                    if (m0_sel_in && s_ready_in) begin
                        state      <= IDLE;
                        last_grant <= 1'b0;
                    end else if (!m0_sel_in) begin
                        state <= IDLE;
                    end
                end
                OWN1: begin
                    if (m1_sel_in && s_ready_in) begin
                        state      <= IDLE;
                        last_grant <= 1'b1;
                    end else if (!m1_sel_in) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Route the owner's request to the slave and the slave's response back to the owner.
    // Ready is qualified by the owner's sel so an abandoned request never completes.
    always_comb begin
        s_address_out     = '0;
        s_sel_out         = 1'b0;
        s_write_mask_out  = '0;
        s_write_value_out = '0;
        m0_ready_out      = 1'b0;
        m0_read_value_out = '0;
        m1_ready_out      = 1'b0;
        m1_read_value_out = '0;
        if (!reset) begin
            unique case (state)
                OWN0: begin
                    s_address_out     = m0_address_in;
                    s_sel_out         = m0_sel_in;
                    s_write_mask_out  = m0_write_mask_in;
                    s_write_value_out = m0_write_value_in;
                    m0_ready_out      = m0_sel_in & s_ready_in;
                    m0_read_value_out = (m0_sel_in && s_ready_in) ? s_read_value_in : '0;
                end
                OWN1: begin
                    s_address_out     = m1_address_in;
                    s_sel_out         = m1_sel_in;
                    s_write_mask_out  = m1_write_mask_in;
                    s_write_value_out = m1_write_value_in;
                    m1_ready_out      = m1_sel_in & s_ready_in;
                    m1_read_value_out = (m1_sel_in && s_ready_in) ? s_read_value_in : '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model and a toggling-ready RAM model.
module tb_ram_arbiter;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] m0_address_in, m1_address_in, s_address_out;
    logic          m0_sel_in, m1_sel_in, s_sel_out;
    logic [3:0]    m0_write_mask_in, m1_write_mask_in, s_write_mask_out;
    logic [31:0]   m0_write_value_in, m1_write_value_in, s_write_value_out;
    logic [31:0]   m0_read_value_out, m1_read_value_out;
    logic          m0_ready_out, m1_ready_out;
    logic [31:0]   s_read_value_in = 32'h0;
    logic          s_ready_in = 1'b0;

    // Master-side request registers
    logic          sel [2];
    logic [AW-1:0] adr [2];
    logic [3:0]    msk [2];
    logic [31:0]   wd  [2];

    assign m0_sel_in         = sel[0];
    assign m0_address_in     = adr[0];
    assign m0_write_mask_in  = msk[0];
    assign m0_write_value_in = wd[0];
    assign m1_sel_in         = sel[1];
    assign m1_address_in     = adr[1];
    assign m1_write_mask_in  = msk[1];
    assign m1_write_value_in = wd[1];

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk               (clk),
        .reset             (reset),
        .m0_address_in     (m0_address_in),
        .m0_sel_in         (m0_sel_in),
        .m0_write_mask_in  (m0_write_mask_in),
        .m0_write_value_in (m0_write_value_in),
        .m0_read_value_out (m0_read_value_out),
        .m0_ready_out      (m0_ready_out),
        .m1_address_in     (m1_address_in),
        .m1_sel_in         (m1_sel_in),
        .m1_write_mask_in  (m1_write_mask_in),
        .m1_write_value_in (m1_write_value_in),
        .m1_read_value_out (m1_read_value_out),
        .m1_ready_out      (m1_ready_out),
        .s_address_out     (s_address_out),
        .s_sel_out         (s_sel_out),
        .s_write_mask_out  (s_write_mask_out),
        .s_write_value_out (s_write_value_out),
        .s_read_value_in   (s_read_value_in),
        .s_ready_in        (s_ready_in)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: owner is -1 (nobody), 0 or 1; last is the last completed master.
    int   own_m  = -1;
    int   last_m = 1;
    logic rdy_q  = 1'b0;

    bit          auto_en = 1'b0;
    int          p_req = 0, p_keep = 0, p_drop = 0;
    bit          use_fixed_rv = 1'b0;
    logic [31:0] fixed_rv = 32'h0;
    bit          seen_rdy [2];
    logic [31:0] seen_rv  [2];
    int          grants [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic new_req(input int i);
        sel[i] = 1'b1;
        adr[i] = $urandom;
        msk[i] = 4'($urandom);
        wd[i]  = $urandom;
    endtask

    task automatic masters_update();
        for (int i = 0; i < 2; i++) begin
            if (sel[i]) begin
                if (seen_rdy[i]) begin
                    if ($urandom_range(0, 99) < p_keep) new_req(i);
                    else sel[i] = 1'b0;
                end else if ($urandom_range(0, 99) < p_drop) begin
                    sel[i] = 1'b0;
                end
            end else if ($urandom_range(0, 99) < p_req) begin
                new_req(i);
            end
        end
    endtask

    // One clock: compare at negedge, advance model and RAM, drive new inputs after posedge.
    task automatic cycle();
        logic [31:0] e_sa, e_sw, e_rv0, e_rv1;
        logic [3:0]  e_sm;
        logic        e_ss, e_r0, e_r1, done, nxt_rdy;
        int          nxt_own, nxt_last;
        @(negedge clk);
        e_sa = 32'h0; e_sw = 32'h0; e_rv0 = 32'h0; e_rv1 = 32'h0;
        e_sm = 4'h0; e_ss = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0; done = 1'b0;
        if (!reset && own_m >= 0) begin
            e_sa = adr[own_m];
            e_ss = sel[own_m];
            e_sm = msk[own_m];
            e_sw = wd[own_m];
            done = sel[own_m] && s_ready_in;
            if (own_m == 0) begin
                e_r0  = done;
                e_rv0 = done ? s_read_value_in : 32'h0;
            end else begin
                e_r1  = done;
                e_rv1 = done ? s_read_value_in : 32'h0;
            end
        end
        check("s_address", s_address_out, e_sa);
        check("s_sel", 32'(s_sel_out), 32'(e_ss));
        check("s_mask", 32'(s_write_mask_out), 32'(e_sm));
        check("s_wdata", s_write_value_out, e_sw);
        check("m0_ready", 32'(m0_ready_out), 32'(e_r0));
        check("m0_rdata", m0_read_value_out, e_rv0);
        check("m1_ready", 32'(m1_ready_out), 32'(e_r1));
        check("m1_rdata", m1_read_value_out, e_rv1);
        seen_rdy[0] = m0_ready_out;
        seen_rdy[1] = m1_ready_out;
        seen_rv[0]  = m0_read_value_out;
        seen_rv[1]  = m1_read_value_out;
        if (m0_ready_out) grants.push_back(0);
        if (m1_ready_out) grants.push_back(1);

        nxt_own  = own_m;
        nxt_last = last_m;
        if (reset) begin
            nxt_own  = -1;
            nxt_last = 1;
        end else if (own_m < 0) begin
            if (sel[0] && sel[1]) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
                nxt_own = 1 - last_m;
`else
                nxt_own = 0;
`endif
            end else if (sel[0]) begin
                nxt_own = 0;
            end else if (sel[1]) begin
                nxt_own = 1;
            end
        end else if (done) begin
            nxt_last = own_m;
            nxt_own  = -1;
        end else if (!sel[own_m]) begin
            nxt_own = -1;
        end
        // RAM: ready toggles high on the cycle after each selected cycle it was low
        nxt_rdy = s_sel_out & ~rdy_q;

        @(posedge clk);
        #1;
        own_m           = nxt_own;
        last_m          = nxt_last;
        rdy_q           = nxt_rdy;
        s_ready_in      = rdy_q;
        s_read_value_in = use_fixed_rv ? fixed_rv : $urandom;
        if (auto_en) masters_update();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic run_manual(input int n);
        for (int k = 0; k < n; k++) begin
            cycle();
            for (int i = 0; i < 2; i++) if (seen_rdy[i]) sel[i] = 1'b0;
        end
    endtask

    initial begin
        int lat;
        logic [31:0] rv;
        for (int i = 0; i < 2; i++) begin
            sel[i] = 1'b0; adr[i] = '0; msk[i] = 4'h0; wd[i] = 32'h0;
        end
        @(posedge clk);
        #1;

        // 1: single m0 read, ready in the 3rd cycle of the request
        do_reset();
        do_reset();
        grants.delete();
        use_fixed_rv    = 1'b1;
        fixed_rv        = 32'hDEAD_BEEF;
        s_read_value_in = fixed_rv;
        adr[0] = 32'h0000_0010; msk[0] = 4'h0; wd[0] = 32'h0; sel[0] = 1'b1;
        lat = 0;
        rv  = 32'h0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            lat++;
            if (seen_rdy[0]) begin
                rv = seen_rv[0];
                break;
            end
        end
        sel[0] = 1'b0;
        check("t1_latency", 32'(lat), 32'd3);
        check("t1_rdata", rv, 32'hDEAD_BEEF);
        run_manual(2);
        check("t1_pulses", 32'(grants.size()), 32'd1);
        use_fixed_rv = 1'b0;

        // 2: m1 write, single ready pulse
        grants.delete();
        adr[1] = 32'h0000_0020; msk[1] = 4'b0011; wd[1] = 32'h1234_5678; sel[1] = 1'b1;
        run_manual(8);
        check("t2_pulses", 32'(grants.size()), 32'd1);
        if (grants.size() > 0) check("t2_who", 32'(grants[0]), 32'd1);

        // 3: continuous contention from both masters
        sel[0] = 1'b0; sel[1] = 1'b0;
        do_reset();
        grants.delete();
        new_req(0);
        new_req(1);
        auto_en = 1'b1; p_req = 100; p_keep = 100; p_drop = 0;
        for (int k = 0; k < 40 && grants.size() < 4; k++) cycle();
        auto_en = 1'b0;
        check("t3_count", 32'(grants.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
            check("t3_grant", 32'(grants[i]), 32'(i % 2));
`else
            check("t3_grant", 32'(grants[i]), 32'd0);
`endif
        end

        // 4: m1 requests while m0 owns the bus
        sel[0] = 1'b0; sel[1] = 1'b0;
        do_reset();
        grants.delete();
        new_req(0);
        cycle();
        new_req(1);
        run_manual(12);
        check("t4_count", 32'(grants.size()), 32'd2);
        if (grants.size() >= 2) begin
            check("t4_first", 32'(grants[0]), 32'd0);
            check("t4_second", 32'(grants[1]), 32'd1);
        end

        // 5: reset while m0 owns the bus, before ready
        sel[0] = 1'b0; sel[1] = 1'b0;
        do_reset();
        grants.delete();
        new_req(0);
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("t5_no_ready", 32'(grants.size()), 32'd0);
        new_req(1);
        run_manual(12);
        check("t5_count", 32'(grants.size() >= 1), 32'd1);
        if (grants.size() >= 1) check("t5_first", 32'(grants[0]), 32'd0);

        // 6: m0 abandons in OWN0, pending m1 is served
        sel[0] = 1'b0; sel[1] = 1'b0;
        do_reset();
        grants.delete();
        new_req(0);
        cycle();
        sel[0] = 1'b0;
        new_req(1);
        run_manual(8);
        check("t6_count", 32'(grants.size()), 32'd1);
        if (grants.size() >= 1) check("t6_who", 32'(grants[0]), 32'd1);

        // Random traffic with occasional abandons and resets
        sel[0] = 1'b0; sel[1] = 1'b0;
        do_reset();
        grants.delete();
        auto_en = 1'b1; p_req = 40; p_keep = 50; p_drop = 4;
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset   = 1'b0;
        auto_en = 1'b0;
        check("rand_traffic", 32'(grants.size() > 100), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
